// File: rtl/sys_ctrl_rx_cmd_pkg.sv
// Shared definitions for the RX-side command sequencer: opcode bytes,
// FSM state encodings, ALU operand register addresses and an opcode decoder.
// The TX-side controller imports the same package.
package sys_ctrl_rx_cmd_pkg;

    localparam logic [7:0] OP_RF_WR   = 8'hAA;
    localparam logic [7:0] OP_RF_RD   = 8'hBB;
    localparam logic [7:0] OP_ALU_OP  = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_ADDR  = 3'd1;
    localparam logic [2:0] ST_WR_DATA  = 3'd2;
    localparam logic [2:0] ST_RD_ADDR  = 3'd3;
    localparam logic [2:0] ST_ALU_OPA  = 3'd4;
    localparam logic [2:0] ST_ALU_OPB  = 3'd5;
    localparam logic [2:0] ST_ALU_FUNC = 3'd6;
    localparam logic [2:0] ST_ALU_WAIT = 3'd7;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    // First state of the frame an opcode starts; ST_IDLE means "not an opcode".
    function automatic logic [2:0] op_to_state(input logic [7:0] op);
        case (op)
            OP_RF_WR:   op_to_state = ST_WR_ADDR;
            OP_RF_RD:   op_to_state = ST_RD_ADDR;
            OP_ALU_OP:  op_to_state = ST_ALU_OPA;
            OP_ALU_NOP: op_to_state = ST_ALU_FUNC;
            default:    op_to_state = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/sys_ctrl_rx_cmd_if.sv
// Bus between the UART receiver / ALU side and the command sequencer.
//   RX_P_DATA/RX_D_VLD/RX_PAR_ERR/RX_STP_ERR : received byte and its flags
//   ALU_OUT_VLD                              : ALU result valid pulse
//   WrEn/RdEn/Address/WrData                 : register-file access
//   ALU_EN/ALU_FUN/CLK_GATE_EN               : ALU control
//   cmd_err                                  : command error pulse
// slave = sequencer side, master = environment side.
interface sys_ctrl_rx_cmd_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]        RX_P_DATA;
    logic              RX_D_VLD;
    logic              RX_PAR_ERR;
    logic              RX_STP_ERR;
    logic              ALU_OUT_VLD;
    logic              WrEn;
    logic              RdEn;
    logic [ADDR_W-1:0] Address;
    logic [7:0]        WrData;
    logic              ALU_EN;
    logic [3:0]        ALU_FUN;
    logic              CLK_GATE_EN;
    logic              cmd_err;

    modport slave (
        input  RX_P_DATA, RX_D_VLD, RX_PAR_ERR, RX_STP_ERR, ALU_OUT_VLD,
        output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, cmd_err
    );

    modport master (
        output RX_P_DATA, RX_D_VLD, RX_PAR_ERR, RX_STP_ERR, ALU_OUT_VLD,
        input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, cmd_err
    );
endinterface

// File: rtl/sys_ctrl_rx_cmd_timer.sv
// Inter-byte timeout counter.
//   CLK, RST   : clock, async active-low reset
//   i_clr      : restart the count
//   i_en       : count enable; count is held at zero while disabled
//   o_expire   : high in the cycle the TIMEOUT-th idle cycle completes
module sys_ctrl_rx_cmd_timer #(
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam logic [TO_W-1:0] TERM = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt != TERM) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A clear in the same cycle overrides expiry, so a byte at the deadline wins.
    assign o_expire = i_en && !i_clr && (r_cnt == TERM);
endmodule

// File: rtl/sys_ctrl_rx_cmd.sv
// Command sequencer behind the UART receiver: parses command frames and
// drives register-file strobes, ALU start/function and the ALU clock gate.
//   CLK, RST : clock, async active-low reset
//   bus      : sys_ctrl_rx_cmd_if.slave (RX bytes in, RF/ALU controls out)
//
// state       | meaning
// ST_IDLE     | waiting for an opcode byte
// ST_WR_ADDR  | RF_WR: expecting address byte
// ST_WR_DATA  | RF_WR: expecting data byte, then WrEn
// ST_RD_ADDR  | RF_RD: expecting address byte, then RdEn
// ST_ALU_OPA  | ALU_OP: operand A, written to OPA_ADDR
// ST_ALU_OPB  | ALU_OP: operand B, written to OPB_ADDR
// ST_ALU_FUNC | expecting function byte, then ALU_EN + clock gate on
// ST_ALU_WAIT | waiting for ALU_OUT_VLD; incoming bytes are dropped
module sys_ctrl_rx_cmd
    import sys_ctrl_rx_cmd_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic                CLK,
    input  logic                RST,
    sys_ctrl_rx_cmd_if.slave    bus
);
    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic       w_byte_ok;
    logic       w_frame_err;
    logic       w_expire;
    logic       w_err;
    logic       w_gate_off;
    logic       w_timer_clr;
    logic       w_timer_en;

    assign w_byte_ok   = bus.RX_D_VLD && !(bus.RX_PAR_ERR || bus.RX_STP_ERR);
    assign w_frame_err = bus.RX_D_VLD &&  (bus.RX_PAR_ERR || bus.RX_STP_ERR);
    // Bytes dropped in ALU_WAIT do not count as accepted; entry to ALU_WAIT
    // is itself an accepted byte, so that clears the timer too.
    assign w_timer_clr = w_byte_ok && (r_state != ST_ALU_WAIT);
    assign w_timer_en  = (r_state != ST_IDLE);

    sys_ctrl_rx_cmd_timer #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .i_clr    (w_timer_clr),
        .i_en     (w_timer_en),
        .o_expire (w_expire)
    );

    always_comb begin
        w_next_state = r_state;
        w_err        = 1'b0;
        w_gate_off   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_byte_ok) begin
                    w_next_state = op_to_state(bus.RX_P_DATA);
                    w_err        = (op_to_state(bus.RX_P_DATA) == ST_IDLE);
                end else if (w_frame_err) begin
                    w_err = 1'b1;
                end
            end
            ST_ALU_WAIT: begin
                if (bus.ALU_OUT_VLD) begin
                    w_next_state = ST_IDLE;
                    w_gate_off   = 1'b1;
                    w_err        = bus.RX_D_VLD;
                end else if (w_expire) begin
                    w_next_state = ST_IDLE;
                    w_gate_off   = 1'b1;
                    w_err        = 1'b1;
                end else if (bus.RX_D_VLD) begin
                    w_err = 1'b1;
                end
            end
            default: begin
                if (w_byte_ok) begin
                    case (r_state)
                        ST_WR_ADDR:  w_next_state = ST_WR_DATA;
                        ST_ALU_OPA:  w_next_state = ST_ALU_OPB;
                        ST_ALU_OPB:  w_next_state = ST_ALU_FUNC;
                        ST_ALU_FUNC: w_next_state = ST_ALU_WAIT;
                        default:     w_next_state = ST_IDLE;
                    endcase
                end else if (w_frame_err || w_expire) begin
                    w_next_state = ST_IDLE;
                    w_gate_off   = 1'b1;
                    w_err        = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.WrEn        <= 1'b0;
            bus.RdEn        <= 1'b0;
            bus.Address     <= '0;
            bus.WrData      <= '0;
            bus.ALU_EN      <= 1'b0;
            bus.ALU_FUN     <= '0;
            bus.CLK_GATE_EN <= 1'b0;
            bus.cmd_err     <= 1'b0;
        end else begin
            bus.WrEn    <= 1'b0;
            bus.RdEn    <= 1'b0;
            bus.ALU_EN  <= 1'b0;
            bus.cmd_err <= w_err;
            if (w_gate_off) begin
                bus.CLK_GATE_EN <= 1'b0;
            end
            if (w_byte_ok) begin
                case (r_state)
                    ST_WR_ADDR: begin
                        bus.Address <= bus.RX_P_DATA[ADDR_W-1:0];
                    end
                    ST_WR_DATA: begin
                        bus.WrData <= bus.RX_P_DATA;
                        bus.WrEn   <= 1'b1;
                    end
                    ST_RD_ADDR: begin
                        bus.Address <= bus.RX_P_DATA[ADDR_W-1:0];
                        bus.RdEn    <= 1'b1;
                    end
                    ST_ALU_OPA: begin
                        bus.Address <= ADDR_W'(OPA_ADDR);
                        bus.WrData  <= bus.RX_P_DATA;
                        bus.WrEn    <= 1'b1;
                    end
                    ST_ALU_OPB: begin
                        bus.Address <= ADDR_W'(OPB_ADDR);
                        bus.WrData  <= bus.RX_P_DATA;
                        bus.WrEn    <= 1'b1;
                    end
                    ST_ALU_FUNC: begin
                        bus.ALU_FUN     <= bus.RX_P_DATA[3:0];
                        bus.ALU_EN      <= 1'b1;
                        bus.CLK_GATE_EN <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sys_ctrl_rx_cmd.sv
module tb_sys_ctrl_rx_cmd;
    localparam int ADDR_W  = 4;
    localparam int TO_W    = 16;
    localparam int TIMEOUT = 64;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    sys_ctrl_rx_cmd_if #(.ADDR_W(ADDR_W)) bus();

    sys_ctrl_rx_cmd #(
        .ADDR_W  (ADDR_W),
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef enum int {EV_WR, EV_RD, EV_ALU, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t          kind;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    function automatic ev_t mk(input ev_kind_t k, input logic [ADDR_W-1:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    // Scoreboard: every strobe pulse pops one expected event.
    int       nfire;
    ev_t      e_mon;
    ev_kind_t got_kind;
    logic     bad;
    always @(negedge CLK) begin
        if (RST === 1'b1) begin
            nfire = $countones({bus.WrEn, bus.RdEn, bus.ALU_EN, bus.cmd_err});
            if (nfire > 1) begin
                checks++;
                errors++;
                $display("FAIL multi_strobe got WrEn=%0b RdEn=%0b ALU_EN=%0b cmd_err=%0b required at most one",
                         bus.WrEn, bus.RdEn, bus.ALU_EN, bus.cmd_err);
            end else if (nfire == 1) begin
                checks++;
                got_kind = bus.WrEn ? EV_WR : bus.RdEn ? EV_RD : bus.ALU_EN ? EV_ALU : EV_ERR;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe got kind=%0d at %0t required none", got_kind, $time);
                end else begin
                    e_mon = exp_q.pop_front();
                    bad = (got_kind != e_mon.kind);
                    if (e_mon.kind == EV_WR)
                        bad = bad || (bus.Address !== e_mon.addr) || (bus.WrData !== e_mon.data);
                    if (e_mon.kind == EV_RD)
                        bad = bad || (bus.Address !== e_mon.addr);
                    if (e_mon.kind == EV_ALU)
                        bad = bad || (bus.ALU_FUN !== e_mon.data[3:0]);
                    if (bad) begin
                        errors++;
                        $display("FAIL scoreboard got kind=%0d addr=%h data=%h fun=%h required kind=%0d addr=%h data=%h at %0t",
                                 got_kind, bus.Address, bus.WrData, bus.ALU_FUN,
                                 e_mon.kind, e_mon.addr, e_mon.data, $time);
                    end
                end
            end
        end
    end

    task automatic send_bad(input logic [7:0] b, input logic par, input logic stp);
        bus.RX_P_DATA  = b;
        bus.RX_PAR_ERR = par;
        bus.RX_STP_ERR = stp;
        bus.RX_D_VLD   = 1'b1;
        @(negedge CLK);
        bus.RX_D_VLD   = 1'b0;
        bus.RX_PAR_ERR = 1'b0;
        bus.RX_STP_ERR = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bad(b, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic drain_check(input string name);
        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending_events got %0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        bus.RX_P_DATA   = 8'h00;
        bus.RX_D_VLD    = 1'b0;
        bus.RX_PAR_ERR  = 1'b0;
        bus.RX_STP_ERR  = 1'b0;
        bus.ALU_OUT_VLD = 1'b0;
        RST = 1'b0;
        idle(3);
        checks++;
        if ({bus.WrEn, bus.RdEn, bus.ALU_EN, bus.cmd_err, bus.CLK_GATE_EN,
             bus.Address, bus.WrData, bus.ALU_FUN} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got WrEn=%b RdEn=%b ALU_EN=%b err=%b gate=%b addr=%h data=%h fun=%h required all 0",
                     bus.WrEn, bus.RdEn, bus.ALU_EN, bus.cmd_err, bus.CLK_GATE_EN,
                     bus.Address, bus.WrData, bus.ALU_FUN);
        end
        RST = 1'b1;
        idle(2);
    endtask

    task automatic test_rf_write;
        exp_q.push_back(mk(EV_WR, 4'h5, 8'h3C));
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h3C);
        drain_check("rf_write");
        checks++;
        if (bus.Address !== 4'h5 || bus.WrData !== 8'h3C) begin
            errors++;
            $display("FAIL rf_write_hold got addr=%h data=%h required addr=5 data=3c", bus.Address, bus.WrData);
        end
    endtask

    task automatic test_rf_read;
        exp_q.push_back(mk(EV_RD, 4'hF, 8'h00));
        send_byte(8'hBB);
        send_byte(8'h0F);
        exp_q.push_back(mk(EV_RD, 4'hF, 8'h00));
        send_byte(8'hBB);
        send_byte(8'h1F);
        drain_check("rf_read");
        checks++;
        if (bus.Address !== 4'hF) begin
            errors++;
            $display("FAIL rf_read_trunc got addr=%h required f", bus.Address);
        end
    endtask

    task automatic test_alu_op;
        exp_q.push_back(mk(EV_WR, 4'h0, 8'h12));
        exp_q.push_back(mk(EV_WR, 4'h1, 8'h34));
        exp_q.push_back(mk(EV_ALU, 4'h0, 8'h01));
        send_byte(8'hCC);
        send_byte(8'h12);
        send_byte(8'h34);
        checks++;
        if (bus.CLK_GATE_EN !== 1'b0) begin
            errors++;
            $display("FAIL alu_gate_early got %b required 0", bus.CLK_GATE_EN);
        end
        send_byte(8'h01);
        idle(4);
        checks++;
        if (bus.CLK_GATE_EN !== 1'b1 || bus.ALU_FUN !== 4'h1) begin
            errors++;
            $display("FAIL alu_gate_on got gate=%b fun=%h required gate=1 fun=1", bus.CLK_GATE_EN, bus.ALU_FUN);
        end
        bus.ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        bus.ALU_OUT_VLD = 1'b0;
        checks++;
        if (bus.CLK_GATE_EN !== 1'b0) begin
            errors++;
            $display("FAIL alu_gate_off got %b required 0", bus.CLK_GATE_EN);
        end
        exp_q.push_back(mk(EV_RD, 4'h3, 8'h00));
        send_byte(8'hBB);
        send_byte(8'h03);
        drain_check("alu_op");
    endtask

    task automatic test_errors;
        exp_q.push_back(mk(EV_ERR, 4'h0, 8'h00));
        send_byte(8'h55);
        idle(2);
        exp_q.push_back(mk(EV_ERR, 4'h0, 8'h00));
        send_byte(8'hAA);
        send_byte(8'h05);
        send_bad(8'h77, 1'b1, 1'b0);
        idle(2);
        exp_q.push_back(mk(EV_WR, 4'h6, 8'h99));
        send_byte(8'hAA);
        send_byte(8'h06);
        send_byte(8'h99);
        // Stop-bit error on an opcode must not start a frame.
        exp_q.push_back(mk(EV_ERR, 4'h0, 8'h00));
        send_bad(8'hAA, 1'b0, 1'b1);
        exp_q.push_back(mk(EV_RD, 4'h4, 8'h00));
        send_byte(8'hBB);
        send_byte(8'h04);
        drain_check("errors_frames");
        // Byte during ALU_WAIT is dropped, gate stays on.
        exp_q.push_back(mk(EV_ALU, 4'h0, 8'h07));
        send_byte(8'hDD);
        send_byte(8'h07);
        exp_q.push_back(mk(EV_ERR, 4'h0, 8'h00));
        send_byte(8'h11);
        idle(1);
        checks++;
        if (bus.CLK_GATE_EN !== 1'b1) begin
            errors++;
            $display("FAIL wait_drop_gate got %b required 1", bus.CLK_GATE_EN);
        end
        // ALU_OUT_VLD and byte together: result wins, byte flagged.
        exp_q.push_back(mk(EV_ERR, 4'h0, 8'h00));
        bus.ALU_OUT_VLD = 1'b1;
        send_byte(8'h22);
        bus.ALU_OUT_VLD = 1'b0;
        checks++;
        if (bus.CLK_GATE_EN !== 1'b0) begin
            errors++;
            $display("FAIL wait_collide_gate got %b required 0", bus.CLK_GATE_EN);
        end
        drain_check("errors_wait");
    endtask

    task automatic test_timeout;
        int first;
        exp_q.push_back(mk(EV_ERR, 4'h0, 8'h00));
        send_byte(8'hAA);
        first = -1;
        for (int n = 1; n <= TIMEOUT + 20; n++) begin
            @(negedge CLK);
            if (bus.cmd_err === 1'b1 && first < 0) first = n;
        end
        checks++;
        if (first != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_frame got cycle %0d required %0d", first, TIMEOUT);
        end
        exp_q.push_back(mk(EV_ALU, 4'h0, 8'h03));
        exp_q.push_back(mk(EV_ERR, 4'h0, 8'h00));
        send_byte(8'hDD);
        send_byte(8'h03);
        first = -1;
        for (int n = 1; n <= TIMEOUT + 20; n++) begin
            @(negedge CLK);
            if (bus.CLK_GATE_EN === 1'b0 && first < 0) first = n;
        end
        checks++;
        if (first != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_gate got cycle %0d required %0d", first, TIMEOUT);
        end
        // Byte landing exactly on the expiry cycle is processed, no abort.
        exp_q.push_back(mk(EV_WR, 4'h5, 8'h5A));
        send_byte(8'hAA);
        idle(TIMEOUT - 1);
        send_byte(8'h05);
        send_byte(8'h5A);
        drain_check("timeout_boundary");
    endtask

    task automatic test_reset_mid;
        exp_q.push_back(mk(EV_ALU, 4'h0, 8'h09));
        send_byte(8'hDD);
        send_byte(8'h09);
        idle(3);
        checks++;
        if (bus.CLK_GATE_EN !== 1'b1) begin
            errors++;
            $display("FAIL mid_gate_on got %b required 1", bus.CLK_GATE_EN);
        end
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if ({bus.WrEn, bus.RdEn, bus.ALU_EN, bus.cmd_err, bus.CLK_GATE_EN,
             bus.Address, bus.WrData, bus.ALU_FUN} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got gate=%b addr=%h data=%h fun=%h required all 0",
                     bus.CLK_GATE_EN, bus.Address, bus.WrData, bus.ALU_FUN);
        end
        @(negedge CLK);
        RST = 1'b1;
        idle(2);
        exp_q.push_back(mk(EV_RD, 4'h2, 8'h00));
        send_byte(8'hBB);
        send_byte(8'h02);
        drain_check("post_reset");
        checks++;
        if (bus.Address !== 4'h2) begin
            errors++;
            $display("FAIL post_reset_addr got %h required 2", bus.Address);
        end
    endtask

    initial begin
        test_reset();
        test_rf_write();
        test_rf_read();
        test_alu_op();
        test_errors();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
